// File: rtl/data_mem_param.sv
// Word-organised data memory with byte/half/word loads and stores plus a memory-mapped LED register.
// Define DATA_MEM_BYTE_ENABLE_EN for single-cycle byte-enable stores; otherwise stores run IDLE->RMW->IDLE.
module data_mem_param #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] LED_ADDR    = 32'h2000,
  parameter int          LED_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          addr,
  input  logic [31:0]          write_data,
  input  logic                 memwrite,
  input  logic                 memread,
  input  logic [3:0]           sign_mask,
  output logic [31:0]          read_data,
  output logic                 clk_stall,
  output logic                 misaligned,
  output logic [LED_WIDTH-1:0] led
);
  localparam int         AW   = $clog2(DEPTH_WORDS);
  localparam logic [2:0] SZ_B = 3'b001;
  localparam logic [2:0] SZ_H = 3'b011;
  localparam logic [2:0] SZ_W = 3'b111;

  typedef enum logic {IDLE, RMW} state_t;
  state_t state, state_nxt;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] led_reg;

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the store data puts the right-aligned value under every candidate lane.
  function automatic logic [31:0] align_store(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      SZ_B:    return {4{wd[7:0]}};
      SZ_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] m;
    m = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
    return m;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] size,
                                          input logic [1:0] off, input logic sext);
    logic [7:0]  b8;
    logic [15:0] h16;
    b8  = w[8*off +: 8];
    h16 = off[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_B:    return {{24{sext & b8[7]}}, b8};
      SZ_H:    return {{16{sext & h16[15]}}, h16};
      default: return w;
    endcase
  endfunction

  // Stage p0: request decode, only meaningful while IDLE
  logic [AW-1:0] idx_p0;
  logic [1:0]    off_p0;
  logic [2:0]    size_p0;
  logic          is_led_p0, mis_p0, req_p0, st_p0, ld_p0, st_ok_p0;
  logic [3:0]    be_p0;
  logic [31:0]   wdat_p0;

  assign idx_p0    = addr[AW+1:2];
  assign off_p0    = addr[1:0];
  assign size_p0   = sign_mask[2:0];
  assign is_led_p0 = (addr[31:2] == LED_ADDR[31:2]);
  assign mis_p0    = is_misaligned(size_p0, off_p0);
  assign req_p0    = (state == IDLE) && (memwrite || memread);
  assign st_p0     = (state == IDLE) && memwrite;
  assign ld_p0     = (state == IDLE) && memread && !memwrite;
  assign st_ok_p0  = st_p0 && !mis_p0;
  assign be_p0     = byte_en(size_p0, off_p0);
  assign wdat_p0   = align_store(size_p0, write_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clk_stall = 1'b0;
    case (state)
      IDLE: begin
`ifndef DATA_MEM_BYTE_ENABLE_EN
        if (st_ok_p0) state_nxt = RMW;
`endif
      end
      RMW: begin
        state_nxt = IDLE;
        clk_stall = 1'b1;
      end
    endcase
  end

`ifdef DATA_MEM_BYTE_ENABLE_EN
  logic we_p0;
  assign we_p0 = st_ok_p0 && !is_led_p0 && rst_n;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we_p0 && be_p0[b]) mem[idx_p0][8*b +: 8] <= wdat_p0[8*b +: 8];
  end
`else
  // Stage p1: captured store and the old word, merged and written back during RMW
  logic [AW-1:0] idx_p1;
  logic [3:0]    be_p1;
  logic [31:0]   wdat_p1, word_p1, merged_p1;
  logic          is_led_p1, vld_p1, we_p1;

  assign vld_p1    = (state == RMW);
  assign merged_p1 = merge_bytes(is_led_p1 ? led_reg : word_p1, wdat_p1, be_p1);
  // rst_n gating makes a reset during the stall cycle abort the write-back.
  assign we_p1     = vld_p1 && !is_led_p1 && rst_n;

  always_ff @(posedge clk) begin
    if (st_ok_p0) begin
      idx_p1    <= idx_p0;
      be_p1     <= be_p0;
      wdat_p1   <= wdat_p0;
      is_led_p1 <= is_led_p0;
      word_p1   <= mem[idx_p0];
    end
    if (we_p1) mem[idx_p1] <= merged_p1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned <= 1'b0;
      read_data  <= '0;
      led_reg    <= '0;
    end else begin
      misaligned <= req_p0 && mis_p0;
      if (ld_p0) begin
        if (mis_p0)         read_data <= '0;
        else if (is_led_p0) read_data <= extract(led_reg, size_p0, off_p0, sign_mask[3]);
        else                read_data <= extract(mem[idx_p0], size_p0, off_p0, sign_mask[3]);
      end
`ifdef DATA_MEM_BYTE_ENABLE_EN
      if (st_ok_p0 && is_led_p0) led_reg <= merge_bytes(led_reg, wdat_p0, be_p0);
`else
      if (vld_p1 && is_led_p1) led_reg <= merged_p1;
`endif
    end
  end

  assign led = led_reg[LED_WIDTH-1:0];

endmodule
